clock_monitor: RTL

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_monitor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/clock_monitor.sv
// Frequency monitor: counts rising edges of an asynchronous mon_clk over fixed clk windows
// and qualifies it with an IDLE/ACQ/LOCK FSM. Optional sticky error via CLOCK_MONITOR_STICKY_ERR_EN.
module clock_monitor #(
  parameter int unsigned WINDOW   = 1024,
  parameter int unsigned EXPECTED = 256,
  parameter int unsigned TOL      = 2,
  parameter int unsigned GOOD_N   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        mon_clk,
  input  logic        clr,
  output logic [15:0] count,
  output logic        count_valid,
  output logic        freq_ok,
  output logic [1:0]  state,
  output logic        err_sticky
);

  localparam int unsigned CW = 16;
  localparam int unsigned GW = 4;
  localparam int unsigned LO = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
  localparam int unsigned HI = EXPECTED + TOL;
  localparam logic [16:0]   LO17      = 17'(LO);
  localparam logic [16:0]   HI17      = 17'(HI);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t        st_q, st_d;
  logic          s1, s2, s3;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] edges_q, edges_d;
  logic [GW-1:0] good_q, good_d;
  logic [GW-1:0] good_inc;
  logic [CW-1:0] count_d;
  logic          count_valid_d;
  logic          freq_ok_d;
  logic          edge_c;
  logic          win_end;
  logic          in_range;
  logic          lock_lost;
  logic [CW-1:0] total;

  // Rising edge seen one stage past the two-flop synchronizer
  assign edge_c   = s2 & ~s3;
  assign win_end  = (st_q != IDLE) && (win_q == WIN_LAST);
  assign total    = (edge_c && (edges_q != 16'hFFFF)) ? edges_q + 16'd1 : edges_q;
  assign in_range = ({1'b0, total} >= LO17) && ({1'b0, total} <= HI17);
  assign good_inc = good_q + 4'd1;
  assign state    = st_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      win_q       <= '0;
      edges_q     <= '0;
      good_q      <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      freq_ok     <= 1'b0;
    end else begin
      st_q        <= st_d;
      s1          <= mon_clk;
      s2          <= s1;
      s3          <= s2;
      win_q       <= win_d;
      edges_q     <= edges_d;
      good_q      <= good_d;
      count       <= count_d;
      count_valid <= count_valid_d;
      freq_ok     <= freq_ok_d;
    end
  end

  // Next state, counters and window-end bookkeeping; en low always wins
  always_comb begin
    st_d          = st_q;
    win_d         = win_q;
    edges_d       = edges_q;
    good_d        = good_q;
    count_d       = count;
    count_valid_d = 1'b0;
    lock_lost     = 1'b0;
    if (!en) begin
      st_d    = IDLE;
      win_d   = '0;
      edges_d = '0;
      good_d  = '0;
    end else begin
      case (st_q)
        IDLE: begin
          st_d    = ACQ;
          win_d   = '0;
          edges_d = '0;
          good_d  = '0;
        end
        ACQ, LOCK: begin
          edges_d = total;
          win_d   = win_q + 16'd1;
          if (win_end) begin
            win_d         = '0;
            edges_d       = '0;
            count_d       = total;
            count_valid_d = 1'b1;
            if (st_q == ACQ) begin
              if (in_range) begin
                good_d = good_inc;
                if (good_inc >= GOOD_LAST) st_d = LOCK;
              end else begin
                good_d = '0;
              end
            end else if (!in_range) begin
              st_d      = ACQ;
              good_d    = '0;
              lock_lost = 1'b1;
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
    freq_ok_d = (st_d == LOCK);
  end

`ifdef CLOCK_MONITOR_STICKY_ERR_EN
  // Set on loss of lock; set beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          err_sticky <= 1'b0;
    else if (lock_lost) err_sticky <= 1'b1;
    else if (clr)       err_sticky <= 1'b0;
  end
`else
  logic unused_sticky;
  assign unused_sticky = clr | lock_lost;
  assign err_sticky    = 1'b0;
`endif

endmodule
